// File: rtl/pkg_global.sv
// Shared display types: active-low 7-segment code type, blank code and hex decode table.
package pkg_global;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low, nibble values 0..F.
  localparam seg7_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/module_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment code lookup.
module module_hex_to_7seg
  import pkg_global::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/module_display_7seg.sv
// Scans a 32-bit word as 8 hex digits onto a common-anode 7-segment display,
// latching the word only at frame boundaries so a frame is never torn.
module module_display_7seg
  import pkg_global::*;
#(
  parameter int TICK_DIV   = 100_000,
  parameter int NUM_DIGITS = 8,
  parameter int DP_POS     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        hold_i,
  input  logic        blank_lz_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX   = CW'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [31:0]   snapshot_q, snapshot_d;
  logic [7:0]    an_q, an_d;
  seg7_t         seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    cur_nibble;
  seg7_t         hex_seg;
  logic [7:0]    nib_zero;
  logic [7:0]    upper_zero;
  logic          blank_digit;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign boundary   = tick && (digit_idx_q == LAST_DIGIT);
  assign cur_nibble = snapshot_q[{digit_idx_q, 2'b00} +: 4];

  module_hex_to_7seg u_hex (
    .nibble_i (cur_nibble),
    .seg_o    (hex_seg)
  );

  // upper_zero[k] is set when nibbles k..7 of the snapshot are all zero.
  always_comb begin
    nib_zero   = '0;
    upper_zero = '0;
    for (int k = 0; k < 8; k++) begin
      nib_zero[k] = (snapshot_q[4*k +: 4] == 4'h0);
    end
    upper_zero[7] = nib_zero[7];
    for (int k = 6; k >= 0; k--) begin
      upper_zero[k] = nib_zero[k] & upper_zero[k+1];
    end
  end

  assign blank_digit = blank_lz_i && (digit_idx_q != 3'd0) && upper_zero[digit_idx_q];

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == LAST_DIGIT) ? 3'd0 : digit_idx_q + 3'd1;
    end
    snapshot_d = snapshot_q;
    frame_d    = 1'b0;
    if (boundary && !hold_i) begin
      snapshot_d = data_i;
      frame_d    = 1'b1;
    end
    an_d  = ~(8'b1 << digit_idx_q);
    seg_d = blank_digit ? SEG_BLANK : hex_seg;
    dp_d  = !(int'(digit_idx_q) == DP_POS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q  <= '0;
      digit_idx_q <= 3'd0;
      snapshot_q  <= 32'h0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      digit_idx_q <= digit_idx_d;
      snapshot_q  <= snapshot_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      frame_q     <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule
